i2s_serializer: RTL and testbench

- Parametrised stereo I2S transmitter for core audio output. Generalises the fixed 16-bit, 4-clocks-per-bit, mono-in-both-slots shifter built inline in core tops.
- Accepts a left/right sample pair through a valid/ready handshake, once per frame. Generates bit clock, word select and serial data, all in one clock domain.
- Adds:
  - selectable I2S or left-justified framing;
  - a mono mode;
  - underrun handling and an underrun flag.
- Sits between the core sound output (after any CDC) and the audio pins.

---
 rtl/i2s_serializer.sv | 147 ++++++++++++++
 tb/tb_i2s_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_serializer.sv
// i2s_serializer
//   Parametrised stereo I2S / left-justified transmitter. A left/right
//   sample pair is accepted once per frame through a valid/ready handshake
//   and serialised MSB first. Bit clock, word select and data are all
//   generated from the single audio clock.
//
// Ports
//   clk        audio clock
//   reset      asynchronous, active-high reset
//   in_left    left sample (signed, SAMPLE_WIDTH bits)
//   in_right   right sample (ignored when MONO=1)
//   in_valid   sample pair available
//   in_ready   high only in the frame-start cycle; transfer = valid & ready
//   sclk       bit clock, CLK_PER_BIT clk cycles per period
//   lrck       word select, 0 = left slot, 1 = right slot
//   dac        serial data, MSB first
//   underrun   one-cycle pulse when a frame started without a valid pair
module i2s_serializer #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int SLOT_WIDTH       = 32,
    parameter int CLK_PER_BIT      = 4,
    parameter bit I2S_MODE         = 1'b1,
    parameter bit MONO             = 1'b0,
    parameter bit HOLD_ON_UNDERRUN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] in_left,
    input  logic [SAMPLE_WIDTH-1:0] in_right,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    sclk,
    output logic                    lrck,
    output logic                    dac,
    output logic                    underrun
);

    localparam int PHASE_W     = $clog2(CLK_PER_BIT);
    localparam int BIT_W       = $clog2(SLOT_WIDTH);
    localparam int PAD_W       = SLOT_WIDTH - SAMPLE_WIDTH;
    // In I2S framing the MSB sits one bit below the top of the slot word so
    // that a single 0 bit goes out on the lrck edge before it.
    localparam int ALIGN_SHIFT = PAD_W - (I2S_MODE ? 1 : 0);

    logic [PHASE_W-1:0]      phase;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    channel;
    logic [SAMPLE_WIDTH-1:0] held_left;
    logic [SAMPLE_WIDTH-1:0] held_right;
    logic [SLOT_WIDTH-1:0]   shift_reg;

    logic                    phase_last;
    logic                    bit_last;
    logic                    slot_start;
    logic                    frame_start;
    logic                    transfer;
    logic [SAMPLE_WIDTH-1:0] next_left;
    logic [SAMPLE_WIDTH-1:0] next_right;
    logic [SAMPLE_WIDTH-1:0] slot_sample;
    logic [SLOT_WIDTH-1:0]   slot_word;
    logic [SLOT_WIDTH-1:0]   shift_next;

    assign phase_last  = (phase == PHASE_W'(CLK_PER_BIT - 1));
    assign bit_last    = (bit_cnt == BIT_W'(SLOT_WIDTH - 1));
    assign slot_start  = (phase == '0) && (bit_cnt == '0);
    assign frame_start = slot_start && !channel;
    // Counters sit at zero while reset is held, so gate ready explicitly.
    assign in_ready    = frame_start && !reset;
    assign transfer    = in_valid && in_ready;

    // Pair that the held registers will hold after this cycle. The left slot
    // load uses it directly so an accepted sample plays in the same frame.
    always_comb begin
        next_left  = held_left;
        next_right = held_right;
        if (transfer) begin
            next_left  = in_left;
            next_right = MONO ? in_left : in_right;
        end else if (!HOLD_ON_UNDERRUN) begin
            next_left  = '0;
            next_right = '0;
        end
    end

    assign slot_sample = channel ? held_right : next_left;
    assign slot_word   = {{PAD_W{1'b0}}, slot_sample} << ALIGN_SHIFT;

    always_comb begin
        shift_next = shift_reg;
        if (slot_start) begin
            shift_next = slot_word;
        end else if (phase == '0) begin
            shift_next = shift_reg << 1;
        end
    end

    // Phase / bit / channel counters step as one chained counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= '0;
            bit_cnt <= '0;
            channel <= 1'b0;
        end else if (phase_last) begin
            phase <= '0;
            if (bit_last) begin
                bit_cnt <= '0;
                channel <= ~channel;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Sample capture happens only at frame start; underrun flags a missed pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_left  <= '0;
            held_right <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= frame_start && !transfer;
            if (frame_start) begin
                held_left  <= next_left;
                held_right <= next_right;
            end
        end
    end

    // Pins are registered from the same counter state, and dac takes the
    // post-load/post-shift MSB so all three pins move on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            sclk      <= 1'b0;
            lrck      <= 1'b0;
            dac       <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            sclk      <= (phase >= PHASE_W'(CLK_PER_BIT / 2));
            lrck      <= channel;
            dac       <= shift_next[SLOT_WIDTH-1];
        end
    end

endmodule

// File: tb/tb_i2s_serializer.sv
// tb_i2s_serializer
//   Self-checking bench for i2s_serializer. Five instances cover the
//   default, left-justified, mono, zero-on-underrun and 24-bit/2-clock
//   configurations. Each cycle the bench records {in_ready, underrun, sclk,
//   lrck, dac} and compares it with a frame-level model of the bit stream.
module tb_i2s_serializer;

    localparam int N = 5;

    int cfg_sw   [N] = '{16, 16, 16, 16, 24};
    int cfg_cpb  [N] = '{4, 4, 4, 4, 2};
    int cfg_i2s  [N] = '{1, 0, 1, 1, 1};
    int cfg_mono [N] = '{0, 0, 1, 0, 0};
    int cfg_hold [N] = '{1, 1, 1, 0, 1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [23:0]  in_l [N];
    logic [23:0]  in_r [N];
    logic         in_v [N];
    logic [N-1:0] rdy_w, und_w, sclk_w, lrck_w, dac_w;

    // Per-frame stimulus and the pair the model says each frame transmits.
    logic [23:0] f_l [8];
    logic [23:0] f_r [8];
    bit          f_v [8];
    logic [23:0] sent_l [8];
    logic [23:0] sent_r [8];

    logic [4:0] obs [0:1023];
    logic [4:0] reset_obs;
    logic [4:0] abort_obs;

    int vectors = 0;
    int miscompares = 0;

    i2s_serializer #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CLK_PER_BIT(4),
                     .I2S_MODE(1'b1), .MONO(1'b0), .HOLD_ON_UNDERRUN(1'b1)) u_def (
        .clk(clk), .reset(reset), .in_left(in_l[0][15:0]), .in_right(in_r[0][15:0]),
        .in_valid(in_v[0]), .in_ready(rdy_w[0]), .sclk(sclk_w[0]), .lrck(lrck_w[0]),
        .dac(dac_w[0]), .underrun(und_w[0]));

    i2s_serializer #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CLK_PER_BIT(4),
                     .I2S_MODE(1'b0), .MONO(1'b0), .HOLD_ON_UNDERRUN(1'b1)) u_lj (
        .clk(clk), .reset(reset), .in_left(in_l[1][15:0]), .in_right(in_r[1][15:0]),
        .in_valid(in_v[1]), .in_ready(rdy_w[1]), .sclk(sclk_w[1]), .lrck(lrck_w[1]),
        .dac(dac_w[1]), .underrun(und_w[1]));

    i2s_serializer #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CLK_PER_BIT(4),
                     .I2S_MODE(1'b1), .MONO(1'b1), .HOLD_ON_UNDERRUN(1'b1)) u_mono (
        .clk(clk), .reset(reset), .in_left(in_l[2][15:0]), .in_right(in_r[2][15:0]),
        .in_valid(in_v[2]), .in_ready(rdy_w[2]), .sclk(sclk_w[2]), .lrck(lrck_w[2]),
        .dac(dac_w[2]), .underrun(und_w[2]));

    i2s_serializer #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CLK_PER_BIT(4),
                     .I2S_MODE(1'b1), .MONO(1'b0), .HOLD_ON_UNDERRUN(1'b0)) u_nohold (
        .clk(clk), .reset(reset), .in_left(in_l[3][15:0]), .in_right(in_r[3][15:0]),
        .in_valid(in_v[3]), .in_ready(rdy_w[3]), .sclk(sclk_w[3]), .lrck(lrck_w[3]),
        .dac(dac_w[3]), .underrun(und_w[3]));

    i2s_serializer #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .CLK_PER_BIT(2),
                     .I2S_MODE(1'b1), .MONO(1'b0), .HOLD_ON_UNDERRUN(1'b1)) u_w24 (
        .clk(clk), .reset(reset), .in_left(in_l[4]), .in_right(in_r[4]),
        .in_valid(in_v[4]), .in_ready(rdy_w[4]), .sclk(sclk_w[4]), .lrck(lrck_w[4]),
        .dac(dac_w[4]), .underrun(und_w[4]));

    function automatic logic [4:0] cur(int idx);
        return {rdy_w[idx], und_w[idx], sclk_w[idx], lrck_w[idx], dac_w[idx]};
    endfunction

    function automatic int frame_len(int idx);
        return 2 * 32 * cfg_cpb[idx];
    endfunction

    function automatic logic [23:0] mask(int idx, logic [23:0] v);
        logic [24:0] m;
        m = (25'd1 << cfg_sw[idx]) - 25'd1;
        return v & m[23:0];
    endfunction

    // Which pair each frame carries: new pair if valid at frame start,
    // otherwise the previous pair (hold) or silence.
    function automatic void build_model(int idx, int nframes);
        logic [23:0] pl, pr;
        pl = '0;
        pr = '0;
        for (int f = 0; f < nframes; f++) begin
            if (f_v[f]) begin
                pl = mask(idx, f_l[f]);
                pr = (cfg_mono[idx] != 0) ? pl : mask(idx, f_r[f]);
            end else if (cfg_hold[idx] == 0) begin
                pl = '0;
                pr = '0;
            end
            sent_l[f] = pl;
            sent_r[f] = pr;
        end
    endfunction

    // Bit k of a slot: optional leading 0, sample MSB first, then zeros.
    function automatic logic model_bit(int idx, logic [23:0] sample, int k);
        int pos;
        pos = k - cfg_i2s[idx];
        if (pos < 0 || pos >= cfg_sw[idx]) return 1'b0;
        return sample[cfg_sw[idx] - 1 - pos];
    endfunction

    // Expected {ready, underrun, sclk, lrck, dac} at cycle j after release.
    // Ready reflects cycle j; pins and underrun reflect cycle j-1.
    function automatic logic [4:0] expect_vec(int idx, int j);
        int fl, s, f, r, chan, bk, ph;
        logic rdy, und, sc, dt;
        fl  = frame_len(idx);
        rdy = ((j % fl) == 0);
        if (j == 0) return {rdy, 4'b0000};
        s    = j - 1;
        f    = s / fl;
        r    = s % fl;
        chan = r / (32 * cfg_cpb[idx]);
        bk   = (r / cfg_cpb[idx]) % 32;
        ph   = r % cfg_cpb[idx];
        und  = (r == 0) && !f_v[f];
        sc   = (ph >= cfg_cpb[idx] / 2);
        dt   = model_bit(idx, (chan != 0) ? sent_r[f] : sent_l[f], bk);
        return {rdy, und, sc, chan[0], dt};
    endfunction

    task automatic set_frame(int f, logic [23:0] l, logic [23:0] r, bit v);
        f_l[f] = l;
        f_r[f] = r;
        f_v[f] = v;
    endtask

    // Reset, release, then drive nframes of stimulus and record observations.
    // Outside frame start, valid and data are randomised and must be ignored.
    task automatic run_frames(int idx, int nframes, int abort_at);
        int fl;
        fl = frame_len(idx);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) in_v[i] = 1'b0;
        #1 reset_obs = cur(idx);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < nframes * fl; j++) begin
            if ((j % fl) == 0) begin
                in_v[idx] = f_v[j / fl];
                in_l[idx] = f_l[j / fl];
                in_r[idx] = f_r[j / fl];
            end else begin
                in_v[idx] = 1'($urandom);
                in_l[idx] = 24'($urandom);
                in_r[idx] = 24'($urandom);
            end
            #1 obs[j] = cur(idx);
            if (j == abort_at) begin
                reset = 1'b1;
                #1 abort_obs = cur(idx);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        set_frame(0, 24'h8001, 24'h7FFE, 1'b1);
        build_model(0, 1);
        run_frames(0, 1, -1);
        vectors++;
        if (reset_obs !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b expected 00000", reset_obs);
        end
        for (int j = 0; j < 256; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(0, j)) begin
                miscompares++;
                $display("[TB] FAIL reset_first_frame cycle %0d: got %b expected %b", j, obs[j], expect_vec(0, j));
            end
        end
    endtask

    task automatic test_default();
        set_frame(0, 24'h8001, 24'h7FFE, 1'b1);
        set_frame(1, 24'h8001, 24'h7FFE, 1'b1);
        set_frame(2, 24'($urandom), 24'($urandom), 1'b1);
        build_model(0, 3);
        run_frames(0, 3, -1);
        for (int j = 0; j < 768; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(0, j)) begin
                miscompares++;
                $display("[TB] FAIL default cycle %0d: got %b expected %b", j, obs[j], expect_vec(0, j));
            end
        end
    endtask

    task automatic test_left_justified();
        set_frame(0, 24'hA5A5, 24'($urandom), 1'b1);
        set_frame(1, 24'($urandom), 24'($urandom), 1'b1);
        build_model(1, 2);
        run_frames(1, 2, -1);
        for (int j = 0; j < 512; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(1, j)) begin
                miscompares++;
                $display("[TB] FAIL left_justified cycle %0d: got %b expected %b", j, obs[j], expect_vec(1, j));
            end
        end
    endtask

    task automatic test_mono();
        set_frame(0, 24'h1234, 24'hFFFF, 1'b1);
        set_frame(1, 24'($urandom), 24'($urandom), 1'b1);
        build_model(2, 2);
        run_frames(2, 2, -1);
        for (int j = 0; j < 512; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(2, j)) begin
                miscompares++;
                $display("[TB] FAIL mono cycle %0d: got %b expected %b", j, obs[j], expect_vec(2, j));
            end
        end
    endtask

    task automatic test_underrun_hold();
        set_frame(0, 24'h0F0F, 24'hF0F0, 1'b1);
        set_frame(1, 24'($urandom), 24'($urandom), 1'b0);
        set_frame(2, 24'($urandom), 24'($urandom), 1'b1);
        build_model(0, 3);
        run_frames(0, 3, -1);
        for (int j = 0; j < 768; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(0, j)) begin
                miscompares++;
                $display("[TB] FAIL underrun_hold cycle %0d: got %b expected %b", j, obs[j], expect_vec(0, j));
            end
        end
    endtask

    task automatic test_underrun_zero();
        set_frame(0, 24'h0F0F, 24'hF0F0, 1'b1);
        set_frame(1, 24'($urandom), 24'($urandom), 1'b0);
        set_frame(2, 24'($urandom), 24'($urandom), 1'b1);
        build_model(3, 3);
        run_frames(3, 3, -1);
        for (int j = 0; j < 768; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(3, j)) begin
                miscompares++;
                $display("[TB] FAIL underrun_zero cycle %0d: got %b expected %b", j, obs[j], expect_vec(3, j));
            end
        end
    endtask

    task automatic test_wide();
        set_frame(0, 24'h800000, 24'($urandom), 1'b1);
        set_frame(1, 24'($urandom), 24'($urandom), 1'b1);
        set_frame(2, 24'($urandom), 24'($urandom), 1'b0);
        build_model(4, 3);
        run_frames(4, 3, -1);
        for (int j = 0; j < 384; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(4, j)) begin
                miscompares++;
                $display("[TB] FAIL wide cycle %0d: got %b expected %b", j, obs[j], expect_vec(4, j));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) set_frame(f, 24'($urandom), 24'($urandom), 1'($urandom));
        build_model(0, 4);
        run_frames(0, 4, -1);
        for (int j = 0; j < 1024; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(0, j)) begin
                miscompares++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", j, obs[j], expect_vec(0, j));
            end
        end
    endtask

    // Reset lands during bit 10 of the right slot, while lrck is high.
    task automatic test_reset_midframe();
        int abort_at;
        abort_at = 128 + 10 * 4 + 2;
        set_frame(0, 24'h8001, 24'h7FFE, 1'b1);
        build_model(0, 1);
        run_frames(0, 1, abort_at);
        for (int j = 0; j <= abort_at; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(0, j)) begin
                miscompares++;
                $display("[TB] FAIL midframe_before cycle %0d: got %b expected %b", j, obs[j], expect_vec(0, j));
            end
        end
        vectors++;
        if (abort_obs !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL midframe_async_clear: got %b expected 00000", abort_obs);
        end
        set_frame(0, 24'($urandom), 24'($urandom), 1'b1);
        build_model(0, 1);
        run_frames(0, 1, -1);
        for (int j = 0; j < 256; j++) begin
            vectors++;
            if (obs[j] !== expect_vec(0, j)) begin
                miscompares++;
                $display("[TB] FAIL midframe_restart cycle %0d: got %b expected %b", j, obs[j], expect_vec(0, j));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            in_l[i] = '0;
            in_r[i] = '0;
            in_v[i] = 1'b0;
        end
        test_reset();
        test_default();
        test_left_justified();
        test_mono();
        test_underrun_hold();
        test_underrun_zero();
        test_wide();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
